// File: rtl/alu_pkg.sv
// Shared constants for the ALU result reader: function codes, 7-segment patterns,
// response error codes and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b0001;
  localparam logic [3:0] FUNC_AND  = 4'b0100;
  localparam logic [3:0] FUNC_OR   = 4'b0101;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;
  localparam logic [3:0] FUNC_SLL  = 4'b1000;
  localparam logic [3:0] FUNC_SRL  = 4'b1001;
  localparam logic [3:0] FUNC_SRA  = 4'b1010;
  localparam logic [3:0] FUNC_PASS = 4'b1111;

  // Segment bit 0 is segment 1; the N flag picks between the two meanings of a shared glyph.
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1_F = 7'b0000110;
  localparam logic [6:0] SEG_2_E = 7'b1011011;
  localparam logic [6:0] SEG_3_D = 7'b1001111;
  localparam logic [6:0] SEG_4_C = 7'b1100110;
  localparam logic [6:0] SEG_5_B = 7'b1101101;
  localparam logic [6:0] SEG_6_A = 7'b1111100;
  localparam logic [6:0] SEG_7_9 = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_ZE      = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_SAMPLE = 2'b10,
    ST_RESP   = 2'b11
  } state_t;

endpackage

// File: rtl/alu_result_reader_seg7_decode.sv
// Combinational 7-segment decoder: {seg, N} back to a 4-bit value plus a legal flag.
module seg7_decode
  import alu_pkg::*;
(
  input  logic [7:0] seg,
  input  logic       n,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = 4'h0;
    legal = 1'b0;
    if (!seg[7]) begin
      case (seg[6:0])
        SEG_0:   if (!n) legal = 1'b1;
        SEG_1_F: begin value = n ? 4'hF : 4'h1; legal = 1'b1; end
        SEG_2_E: begin value = n ? 4'hE : 4'h2; legal = 1'b1; end
        SEG_3_D: begin value = n ? 4'hD : 4'h3; legal = 1'b1; end
        SEG_4_C: begin value = n ? 4'hC : 4'h4; legal = 1'b1; end
        SEG_5_B: begin value = n ? 4'hB : 4'h5; legal = 1'b1; end
        SEG_6_A: begin value = n ? 4'hA : 4'h6; legal = 1'b1; end
        SEG_7_9: begin value = n ? 4'h9 : 4'h7; legal = 1'b1; end
        SEG_8:   if (n) begin value = 4'h8; legal = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_reader.sv
// Host-side reader for the 4-bit ALU tile: drives operands, waits for a stable display
// and returns the decoded result. Define ALU_CHECK_EN to add the golden-model cross-check.
//   state  | meaning
//   IDLE   | ready for a request
//   SETTLE | operands driven, waiting for the ALU to settle
//   SAMPLE | sampling {seg,flags} until stable or timed out
//   RESP   | response presented, waiting for rsp_ready
module alu_result_reader
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int STABLE_SAMPLES = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [3:0] req_func,
  output logic [7:0] alu_ui,
  output logic [3:0] alu_func,
  input  logic [7:0] alu_seg,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_value,
  output logic [3:0] rsp_flags,
  output logic [1:0] rsp_err,
  output logic       rsp_mismatch
);

  localparam int SETW = $clog2(SETTLE_CYCLES + 1);
  localparam int STW  = $clog2(STABLE_SAMPLES + 1);
  localparam int TOW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SETW-1:0] SET_LOAD   = SETW'(SETTLE_CYCLES - 1);
  localparam logic [STW-1:0]  STABLE_TGT = STW'(STABLE_SAMPLES);
  localparam logic [TOW-1:0]  TO_LOAD    = TOW'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  logic [SETW-1:0] settle_cnt;
  logic [STW-1:0]  stable_cnt, stable_next;
  logic [TOW-1:0]  to_cnt;
  logic [11:0]     prev_sample, sample_now;
  logic            is_stable, sample_done;
  logic [3:0]      dec_value;
  logic            dec_legal;
  logic [1:0]      err_now;
  logic            mismatch_now;

  seg7_decode u_dec (
    .seg   (alu_seg),
    .n     (alu_flags[2]),
    .value (dec_value),
    .legal (dec_legal)
  );

  // stable_cnt == 0 marks the first sample of an operation, which never counts as a repeat.
  always_comb begin
    sample_now  = {alu_seg, alu_flags};
    stable_next = ((stable_cnt != '0) && (sample_now == prev_sample)) ? stable_cnt + 1'b1 : STW'(1);
    is_stable   = (stable_next == STABLE_TGT);
    sample_done = is_stable || (to_cnt == '0);
    if (!is_stable)                             err_now = ERR_TIMEOUT;
    else if (!dec_legal)                        err_now = ERR_ILLEGAL;
    else if (alu_flags[3] != (dec_value == 4'h0)) err_now = ERR_ZE;
    else                                        err_now = ERR_OK;
  end

`ifdef ALU_CHECK_EN
  logic [3:0] gm_a, gm_b, gm_bb, gm_value;
  logic [4:0] gm_sum;
  logic       gm_c, gm_v;

  // Shift amount is taken from B[1:0].
  always_comb begin
    gm_a     = alu_ui[3:0];
    gm_b     = alu_ui[7:4];
    gm_bb    = alu_func[0] ? (~gm_b + 4'd1) : gm_b;
    gm_sum   = {1'b0, gm_a} + {1'b0, gm_bb};
    gm_c     = gm_sum[4];
    gm_v     = (gm_a[3] == gm_bb[3]) && (gm_sum[3] != gm_a[3]);
    gm_value = gm_a;
    case (alu_func)
      FUNC_ADD: gm_value = gm_a + gm_b;
      FUNC_SUB: gm_value = gm_a - gm_b;
      FUNC_AND: gm_value = gm_a & gm_b;
      FUNC_OR:  gm_value = gm_a | gm_b;
      FUNC_XOR: gm_value = gm_a ^ gm_b;
      FUNC_SLL: gm_value = gm_a << gm_b[1:0];
      FUNC_SRL: gm_value = gm_a >> gm_b[1:0];
      FUNC_SRA: gm_value = 4'($signed(gm_a) >>> gm_b[1:0]);
      default:  gm_value = gm_a;
    endcase
    mismatch_now = (err_now == ERR_OK) &&
                   ({dec_value, alu_flags[1:0]} != {gm_value, gm_c, gm_v});
  end
`else
  assign mismatch_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_next = ST_SAMPLE;
      ST_SAMPLE: if (sample_done) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ui       <= '0;
      alu_func     <= FUNC_PASS;
      rsp_value    <= '0;
      rsp_flags    <= '0;
      rsp_err      <= '0;
      rsp_mismatch <= 1'b0;
      settle_cnt   <= '0;
      stable_cnt   <= '0;
      to_cnt       <= '0;
      prev_sample  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          alu_ui     <= {req_b, req_a};
          alu_func   <= req_func;
          settle_cnt <= SET_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
          else begin
            stable_cnt <= '0;
            to_cnt     <= TO_LOAD;
          end
        end
        ST_SAMPLE: begin
          prev_sample <= sample_now;
          stable_cnt  <= stable_next;
          if (!sample_done) to_cnt <= to_cnt - 1'b1;
          else begin
            rsp_value    <= dec_value;
            rsp_flags    <= alu_flags;
            rsp_err      <= err_now;
            rsp_mismatch <= mismatch_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_reader.sv
// Scoreboard bench for alu_result_reader: a behavioural ALU (with forcing) drives the
// DUT, stimulus pushes hand-computed expectations, a monitor pops and compares responses.
module tb_alu_result_reader;

`ifdef ALU_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a, req_b, req_func;
  logic [7:0] alu_ui;
  logic [3:0] alu_func;
  logic [7:0] alu_seg;
  logic [3:0] alu_flags;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_value;
  logic [3:0] rsp_flags;
  logic [1:0] rsp_err;
  logic       rsp_mismatch;

  alu_result_reader dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_func     (req_func),
    .alu_ui       (alu_ui),
    .alu_func     (alu_func),
    .alu_seg      (alu_seg),
    .alu_flags    (alu_flags),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_value    (rsp_value),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .rsp_mismatch (rsp_mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU tile: shows |signed result| on the display with N as sign.
  logic [3:0] m_a, m_b, m_bb, m_r, m_mag, m_flags;
  logic [4:0] m_sum;
  logic [6:0] m_glyph;
  always_comb begin
    m_a   = alu_ui[3:0];
    m_b   = alu_ui[7:4];
    m_bb  = alu_func[0] ? (~m_b + 4'd1) : m_b;
    m_sum = {1'b0, m_a} + {1'b0, m_bb};
    case (alu_func)
      4'h0:    m_r = m_a + m_b;
      4'h1:    m_r = m_a - m_b;
      default: m_r = m_a;
    endcase
    m_mag = m_r[3] ? (~m_r + 4'd1) : m_r;
    case (m_mag)
      4'd0: m_glyph = 7'h3F;  4'd1: m_glyph = 7'h06;  4'd2: m_glyph = 7'h5B;
      4'd3: m_glyph = 7'h4F;  4'd4: m_glyph = 7'h66;  4'd5: m_glyph = 7'h6D;
      4'd6: m_glyph = 7'h7C;  4'd7: m_glyph = 7'h07;  4'd8: m_glyph = 7'h7F;
      default: m_glyph = 7'h00;
    endcase
    m_flags = {m_r == 4'h0, m_r[3], m_sum[4], (m_a[3] == m_bb[3]) && (m_sum[3] != m_a[3])};
  end

  logic [1:0] mode;    // 0 model, 1 forced, 2 toggling every cycle
  logic [7:0] f_seg;
  logic [3:0] f_flags;
  assign alu_seg   = (mode == 2'd1) ? f_seg   : (mode == 2'd2) ? (cyc[0] ? 8'h06 : 8'h3F) : {1'b0, m_glyph};
  assign alu_flags = (mode == 2'd1) ? f_flags : (mode == 2'd2) ? (cyc[0] ? 4'h0 : 4'h8)   : m_flags;

  typedef struct {
    logic [3:0] value;
    logic [3:0] flags;
    logic [1:0] err;
    logic       mm;
    int         lat;
    int         t;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the first cycle of each response against the scoreboard head.
  initial begin : monitor
    exp_t e;
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got value %0h err %0h with no pending request", rsp_value, rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_value", rsp_value, e.value);
          chk("rsp_flags", rsp_flags, e.flags);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_mismatch", rsp_mismatch, e.mm);
          chk("latency", cyc - e.t, e.lat);
        end
      end else if (!rsp_valid) begin
        seen = 1'b0;
      end
    end
  end

  task automatic issue_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f,
                          input logic [3:0] ev, input logic [3:0] ef, input logic [1:0] ee,
                          input logic em, input int lat, input bit tog);
    exp_t e;
    @(negedge clk);
    req_a = a; req_b = b; req_func = f; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.value = ev; e.flags = ef; e.err = ee; e.mm = em; e.lat = lat; e.t = cyc;
    if (tog) begin
      // last sample is taken while cyc == t+17
      if (((cyc + 17) % 2) == 1) begin e.value = 4'h1; e.flags = 4'h0; end
      else                       begin e.value = 4'h0; e.flags = 4'h8; end
    end
    sb.push_back(e);
    @(negedge clk);
    chk("alu_ui", alu_ui, {b, a});
    chk("alu_func", alu_func, f);
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: operation not completed within 80 cycles, pending %0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f,
                    input logic [3:0] ev, input logic [3:0] ef, input logic [1:0] ee,
                    input logic em, input int lat);
    issue_op(a, b, f, ev, ef, ee, em, lat, 1'b0);
    wait_idle();
  endtask

  task automatic forced_op(input logic [7:0] seg, input logic [3:0] fl, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] ev, input logic [1:0] ee,
                           input logic em);
    @(negedge clk);
    mode = 2'd1; f_seg = seg; f_flags = fl;
    op(a, b, 4'h0, ev, fl, ee, em, 4);
    mode = 2'd0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_func = '0;
    mode = 2'd0; f_seg = '0; f_flags = '0;
    repeat (3) @(negedge clk);
    chk("rst_alu_ui", alu_ui, 0);
    chk("rst_alu_func", alu_func, 4'hF);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_value", rsp_value, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_mismatch", rsp_mismatch, 0);
    reset = 1'b0;

    //  a     b     f     value flags err   mm    lat
    op(4'h3, 4'h2, 4'h0, 4'h5, 4'h0, 2'd0, 1'b0, 4);
    op(4'h2, 4'h3, 4'h1, 4'hF, 4'h4, 2'd0, 1'b0, 4);
    op(4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 2'd0, 1'b0, 4);
    op(4'h9, 4'h9, 4'h1, 4'h0, 4'hA, 2'd0, 1'b0, 4);
    op(4'h1, 4'h3, 4'h1, 4'hE, 4'h4, 2'd0, 1'b0, 4);
    op(4'h8, 4'h1, 4'h1, 4'h7, 4'h3, 2'd0, 1'b0, 4);
    op(4'h9, 4'h0, 4'h0, 4'h9, 4'h4, 2'd0, 1'b0, 4);
    op(4'h7, 4'h1, 4'h0, 4'h8, 4'h5, 2'd0, 1'b0, 4);
    op(4'h6, 4'h0, 4'hF, 4'h6, 4'h0, 2'd0, 1'b0, 4);

    //        seg    flags  a     b     value err   mm
    forced_op(8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b0);
    forced_op(8'h3F, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2, 1'b0);
    forced_op(8'h86, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 1'b0);
    forced_op(8'h3F, 4'h4, 4'h0, 4'h0, 4'h0, 2'd1, 1'b0);
    forced_op(8'h07, 4'h5, 4'h7, 4'h1, 4'h9, 2'd0, CHECK_EN);

    @(negedge clk);
    mode = 2'd2;
    issue_op(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3, 1'b0, 18, 1'b1);
    wait_idle();
    mode = 2'd0;

    // Response held under backpressure; requests ignored while busy.
    rsp_ready = 1'b0;
    issue_op(4'h3, 4'h2, 4'h0, 4'h5, 4'h0, 2'd0, 1'b0, 4, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("bp_rsp_seen", got, 1);
    req_a = 4'hA; req_b = 4'hB; req_func = 4'h6; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_value", rsp_value, 4'h5);
      chk("bp_rsp_flags", rsp_flags, 4'h0);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_alu_ui", alu_ui, 8'h23);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop_valid", rsp_valid, 0);
    chk("bp_back_idle", req_ready, 1);
    chk("bp_alu_func_hold", alu_func, 4'h0);
    wait_idle();

    // Reset while settling aborts the operation.
    @(negedge clk);
    req_a = 4'h5; req_b = 4'h1; req_func = 4'h1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("settle_busy", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_alu_func", alu_func, 4'hF);
    chk("midrst_alu_ui", alu_ui, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 0);
    op(4'h2, 4'h2, 4'h0, 4'h4, 4'h0, 2'd0, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
